// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one pulse-handshake CDC channel.
// One transfer at a time: send pulse, wait for the returned ack to rise and fall, then strobe done.
module handshake_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clkA,
  input  logic                     rstA_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     ack_i,
  output logic                     pulse_o,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t           state;
  state_t           stateNext;
  logic [OW-1:0]    winner;
  logic [CW-1:0]    timeCnt;
  logic [N_REQ-1:0] ownerHot;
  logic [N_REQ-1:0] doneNext;
  logic             timeoutNext;
  logic             timeoutHit;
  logic             waiting;

  // Round-robin search starting just past the last-served requester.
  always_comb begin : arbitrate
    int   idx;
    logic found;
    winner = owner;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(owner) + i) % N_REQ;
      if (!found && req[OW'(idx)]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign ownerHot = N_REQ'(1) << owner;
  assign waiting  = (state == WAIT_HI) || (state == WAIT_LO);
  // Registered strobe lands in the cycle the count reaches TIMEOUT-1; >= guards
  // the case where ack rose in WAIT_HI on the same edge as the threshold.
  assign timeoutHit = timeCnt >= CW'(TIMEOUT - 2);

  always_comb begin
    stateNext   = state;
    doneNext    = '0;
    timeoutNext = 1'b0;
    case (state)
      IDLE: begin
        if ((|req) && !ack_i) stateNext = SEND;
      end
      SEND: stateNext = WAIT_HI;
      WAIT_HI: begin
        if (ack_i) begin
          stateNext = WAIT_LO;
        end else if (timeoutHit) begin
          stateNext   = IDLE;
          timeoutNext = 1'b1;
        end
      end
      WAIT_LO: begin
        // Completion takes priority over a coincident timeout.
        if (!ack_i) begin
          stateNext = IDLE;
          doneNext  = ownerHot;
        end else if (timeoutHit) begin
          stateNext   = IDLE;
          timeoutNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (!rstA_n) begin
      state       <= IDLE;
      owner       <= OW'(N_REQ - 1);
      timeCnt     <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= stateNext;
      done        <= doneNext;
      timeout_err <= timeoutNext;
      if (state == IDLE && stateNext == SEND) owner <= winner;
      if (stateNext == SEND) begin
        timeCnt <= '0;
      end else if (waiting) begin
        timeCnt <= timeCnt + CW'(1);
      end
    end
  end

  assign pulse_o = (state == SEND);
  assign grant   = pulse_o ? ownerHot : '0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter: expected pulse/done/timeout events are queued
// by the stimulus and retired by an independent output monitor.
module tb_handshake_arbiter;
  localparam int N = 4;
  localparam int TO = 8;
  localparam int K_PULSE = 0;
  localparam int K_DONE  = 1;
  localparam int K_TO    = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] val;
  } ev_t;

  logic         clkA;
  logic         rstA_n;
  logic [N-1:0] req;
  logic         ack;
  logic         pulse_o;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout_err;

  int  vectors = 0;
  int  errors  = 0;
  ev_t sb[$];

  handshake_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clkA(clkA),
    .rstA_n(rstA_n),
    .req(req),
    .ack_i(ack),
    .pulse_o(pulse_o),
    .grant(grant),
    .done(done),
    .owner(owner),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clkA = 1'b0;
    forever #5 clkA = ~clkA;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clkA) begin
    ev_t e;
    int  k;
    logic [N-1:0] v;
    if (pulse_o === 1'b1 || done !== '0 || timeout_err === 1'b1) begin
      k = pulse_o ? K_PULSE : (timeout_err ? K_TO : K_DONE);
      v = pulse_o ? grant : done;
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got kind %0d value %0h, required no event", k, v);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", 32'(k), 32'(e.kind));
        chk("sb_val", 32'(v), 32'(e.val));
      end
    end
  end

  task automatic sendChk(input logic [N-1:0] g);
    sb.push_back(ev_t'{K_PULSE, g});
    @(negedge clkA);
    chk("pulse", 32'(pulse_o), 32'(1));
    chk("grant", 32'(grant), 32'(g));
    chk("busy_send", 32'(busy), 32'(1));
  endtask

  task automatic ackCycle(input logic [N-1:0] g, input int dly, input int len);
    sb.push_back(ev_t'{K_DONE, g});
    repeat (dly) @(negedge clkA);
    ack = 1'b1;
    repeat (len) @(negedge clkA);
    ack = 1'b0;
    @(negedge clkA);
    chk("done", 32'(done), 32'(g));
    chk("busy_done", 32'(busy), 32'(0));
    chk("to_at_done", 32'(timeout_err), 32'(0));
  endtask

  task automatic xfer(input logic [N-1:0] g, input int dly, input int len);
    sendChk(g);
    ackCycle(g, dly, len);
  endtask

  task automatic checkQuiet(input string name);
    chk({name, "_pulse"}, 32'(pulse_o), 32'(0));
    chk({name, "_grant"}, 32'(grant), 32'(0));
    chk({name, "_done"}, 32'(done), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
    chk({name, "_to"}, 32'(timeout_err), 32'(0));
  endtask

  initial begin
    rstA_n = 1'b0;
    req    = '0;
    ack    = 1'b0;
    repeat (3) @(negedge clkA);
    checkQuiet("rst");
    chk("rst_owner", 32'(owner), 32'(3));

    // Single transfer, requested in the first cycle out of reset.
    rstA_n = 1'b1;
    req    = 4'b0001;
    xfer(4'b0001, 3, 4);
    req = '0;
    @(negedge clkA);
    checkQuiet("after_single");
    chk("owner_single", 32'(owner), 32'(0));

    // Full rotation with all requesters held high, starting from reset.
    rstA_n = 1'b0;
    @(negedge clkA);
    rstA_n = 1'b1;
    req    = 4'b1111;
    xfer(4'b0001, 1, 2);
    xfer(4'b0010, 1, 2);
    xfer(4'b0100, 2, 1);
    xfer(4'b1000, 1, 3);
    xfer(4'b0001, 1, 2);
    req = '0;
    @(negedge clkA);
    chk("rr_idle_busy", 32'(busy), 32'(0));

    // No acknowledge: timeout strobe eight cycles after SEND, then the next requester.
    req = 4'b0011;
    sendChk(4'b0010);
    sb.push_back(ev_t'{K_TO, 4'b0000});
    repeat (7) @(negedge clkA);
    chk("to_early", 32'(timeout_err), 32'(0));
    chk("to_busy", 32'(busy), 32'(1));
    @(negedge clkA);
    chk("to_strobe", 32'(timeout_err), 32'(1));
    chk("to_nodone", 32'(done), 32'(0));
    xfer(4'b0001, 1, 1);
    req = '0;

    // Ack falls on the same edge the timeout would fire: done must win.
    @(negedge clkA);
    req = 4'b0100;
    sendChk(4'b0100);
    sb.push_back(ev_t'{K_DONE, 4'b0100});
    repeat (2) @(negedge clkA);
    ack = 1'b1;
    repeat (5) @(negedge clkA);
    ack = 1'b0;
    @(negedge clkA);
    chk("coin_done", 32'(done), 32'(4'b0100));
    chk("coin_to", 32'(timeout_err), 32'(0));
    req = '0;

    // Ack still high in IDLE blocks the next send until it drops.
    @(negedge clkA);
    ack = 1'b1;
    req = 4'b0010;
    repeat (3) begin
      @(negedge clkA);
      chk("ackhi_nopulse", 32'(pulse_o), 32'(0));
    end
    chk("ackhi_owner", 32'(owner), 32'(2));
    ack = 1'b0;
    xfer(4'b0010, 1, 2);
    req = '0;

    // Requester drops its request during WAIT_HI; transfer still completes.
    @(negedge clkA);
    req = 4'b0100;
    sendChk(4'b0100);
    @(negedge clkA);
    req = '0;
    ackCycle(4'b0100, 1, 2);
    repeat (3) @(negedge clkA);

    // Reset in WAIT_LO abandons the transfer silently; requester 0 wins afterwards.
    req = 4'b0010;
    sendChk(4'b0010);
    @(negedge clkA);
    ack = 1'b1;
    repeat (2) @(negedge clkA);
    rstA_n = 1'b0;
    @(negedge clkA);
    checkQuiet("midrst");
    chk("midrst_owner", 32'(owner), 32'(3));
    ack    = 1'b0;
    req    = 4'b0001;
    rstA_n = 1'b1;
    xfer(4'b0001, 1, 1);
    req = '0;

    repeat (5) @(negedge clkA);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
